counter: RTL and testbench

Synchronous up-counter with a parameterised width. It saturates at its maximum value by default and can be built to wrap instead. It counts clock edges while enabled and provides a user-controlled clear. It sits beside register-mapped control logic: a control register bit drives `user_reset`, and a board/system-level arming signal drives `areset`.

---
 rtl/counter.sv | 46 ++++
 tb/tb_counter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/counter.sv
// Saturating up-counter with synchronous clear (user_reset) and active-low arming (areset).
// Defining COUNTER_WRAP_EN builds a wrapping counter instead of a saturating one.
module counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             user_reset,
    input  logic             areset,
    output logic [WIDTH-1:0] dataout
);

    localparam logic [WIDTH-1:0] MaxCount = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;

    assign at_max = (count_q == MaxCount);

    // user_reset has priority; it is applied in the register block below.
    always_comb begin
        count_d = count_q;
        if (!areset) begin
            count_d = '0;
        end else if (at_max) begin
`ifdef COUNTER_WRAP_EN
            count_d = '0;
`else
            count_d = count_q;
`endif
        end else begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (user_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign dataout = count_q;

endmodule

// File: tb/tb_counter.sv
// Table-driven bench for counter (WIDTH=4); expectations follow COUNTER_WRAP_EN if defined.
module tb_counter;

    logic       clk;
    logic       user_reset;
    logic       areset;
    logic [3:0] dataout;

    int checks;
    int failures;

    typedef struct {
        logic       ur;
        logic       ar;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    counter #(
        .WIDTH(4)
    ) dut (
        .clk       (clk),
        .user_reset(user_reset),
        .areset    (areset),
        .dataout   (dataout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic void add(input logic ur, input logic ar, input logic [3:0] exp);
        vec_t v;
        v.ur  = ur;
        v.ar  = ar;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] exp);
        checks++;
        if (dataout !== exp) begin
            failures++;
            $display("FAIL %s: dataout=%0d expected=%0d at %0t", name, dataout, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit after it.
    task automatic step(input logic ur, input logic ar, input logic [3:0] exp, input string name);
        user_reset = ur;
        areset     = ar;
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    initial begin
        int n;
        checks     = 0;
        failures   = 0;
        user_reset = 1'b1;
        areset     = 1'b0;

        // Reset and hold disarmed for two edges.
        add(1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b0, 4'd0);
        // Arm: 23 counting edges; saturates at 15 (wraps to 7 in wrap build).
        for (int i = 1; i <= 23; i++) begin
`ifdef COUNTER_WRAP_EN
            add(1'b0, 1'b1, 4'(i % 16));
`else
            add(1'b0, 1'b1, (i > 15) ? 4'd15 : 4'(i));
`endif
        end
        // User clear for two edges, then recount seven.
        add(1'b1, 1'b1, 4'd0);
        add(1'b1, 1'b1, 4'd0);
        for (int i = 1; i <= 7; i++) add(1'b0, 1'b1, 4'(i));
        // Bring count to 5, then disarm for one edge and recount two.
        add(1'b1, 1'b1, 4'd0);
        for (int i = 1; i <= 5; i++) add(1'b0, 1'b1, 4'(i));
        add(1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b1, 4'd1);
        add(1'b0, 1'b1, 4'd2);
        // Both clears together.
        add(1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, 4'd1);

        n = 0;
        foreach (vecs[i]) begin
            step(vecs[i].ur, vecs[i].ar, vecs[i].exp, $sformatf("vec%0d", n));
            n++;
        end

        // At count 1: inputs changing mid-cycle must not reach dataout before the edge.
        #3;
        areset = 1'b0;
        #2;
        check("no_comb_areset", 4'd1);
        user_reset = 1'b1;
        #2;
        check("no_comb_user_reset", 4'd1);
        @(posedge clk);
        #1;
        check("clear_after_edge", 4'd0);

        // Multi-edge user_reset pulse keeps dataout at 0 for each edge.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 4'd0, $sformatf("ur_hold%0d", k));
        step(1'b0, 1'b1, 4'd1, "resume_from_zero");

        // 17 counting edges from 0.
        step(1'b1, 1'b1, 4'd0, "pre_wrap_clear");
        for (int i = 1; i <= 16; i++) begin
            user_reset = 1'b0;
            areset     = 1'b1;
            @(posedge clk);
        end
        #1;
`ifdef COUNTER_WRAP_EN
        check("wrap16", 4'd0);
        step(1'b0, 1'b1, 4'd1, "wrap17");
`else
        check("sat16", 4'd15);
        step(1'b0, 1'b1, 4'd15, "sat17");
`endif
        step(1'b1, 1'b0, 4'd0, "both_clear");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
